// File: rtl/mem_stage.sv
// mem_stage: memory stage of the GPU-frame pipeline (EX -> MEM -> WB).
//   Executes LDB/LDW/STB/STW against an internal word-addressed data RAM.
//   Each access takes MEM_LATENCY extra cycles and stalls upstream while it
//   is in flight. Every other op passes through with one cycle of latency.
//   All state updates on the falling edge of I_CLOCK. I_RESET is synchronous
//   and active-high.
// Ports:
//   I_CLOCK, I_RESET, I_LOCK          clock, sync reset, pipeline enable
//   I_* (EX bundle)                   op, PC, IR, dest, ALU value, CC, MAR,
//                                     MDR, valid, reg/CC write enables
//   O_* (WB bundle)                   registered copies of the above, plus
//                                     load data / CC and O_AddrFault
//   O_MemStall_Signal                 combinational stall to FE/DE/EX
//   O_RegWEn_Signal, O_CCWEn_Signal   combinational write intents to DE
// Optional feature (define MEM_MMIO_EN):
//   Adds the O_LEDR[9:0] and O_HEX[15:0] registers at 0xFFF0 and 0xFFF2.
//   Accesses to them complete without stalling and never fault.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 16
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef OP_LDB
`define OP_LDB 8'h20
`define OP_LDW 8'h21
`define OP_STB 8'h22
`define OP_STW 8'h23
`endif

module mem_stage #(
  parameter int unsigned DMEM_DEPTH  = 1024,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [`PC_WIDTH-1:0]     I_PC,
  input  logic [`IR_WIDTH-1:0]     I_IR,
  input  logic [3:0]               I_DestRegIdx,
  input  logic [`REG_WIDTH-1:0]    I_DestValue,
  input  logic [2:0]               I_CCValue,
  input  logic [`REG_WIDTH-1:0]    I_MARValue,
  input  logic [`REG_WIDTH-1:0]    I_MDRValue,
  input  logic                     I_EX_Valid,
  input  logic                     I_RegWEn,
  input  logic                     I_CCWEn,
  output logic                     O_LOCK,
  output logic [`OPCODE_WIDTH-1:0] O_Opcode,
  output logic [`PC_WIDTH-1:0]     O_PC,
  output logic [`IR_WIDTH-1:0]     O_IR,
  output logic [3:0]               O_DestRegIdx,
  output logic [`REG_WIDTH-1:0]    O_DestValue,
  output logic [2:0]               O_CCValue,
  output logic                     O_MEM_Valid,
  output logic                     O_RegWEn,
  output logic                     O_CCWEn,
  output logic                     O_AddrFault,
`ifdef MEM_MMIO_EN
  output logic [9:0]               O_LEDR,
  output logic [15:0]              O_HEX,
`endif
  output logic                     O_MemStall_Signal,
  output logic                     O_RegWEn_Signal,
  output logic                     O_CCWEn_Signal
);

  localparam int unsigned AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [`REG_WIDTH-1:0] mem [DMEM_DEPTH];

  logic is_load, is_store, is_byte, mem_op, ld, st;
  logic [`REG_WIDTH-2:0] word_idx;
  logic [AW-1:0] ram_idx;
  logic in_range, mmio_hit, fast, stall, complete, ram_we;
  logic [`REG_WIDTH-1:0] rd_word, raw_word, ld_data, wr_word;
  logic [7:0] ld_lane;
  logic [2:0] ld_cc;

  logic                     lock_q, lock_d;
  logic [`OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [`PC_WIDTH-1:0]     pc_q, pc_d;
  logic [`IR_WIDTH-1:0]     ir_q, ir_d;
  logic [3:0]               dst_idx_q, dst_idx_d;
  logic [`REG_WIDTH-1:0]    dst_val_q, dst_val_d;
  logic [2:0]               cc_q, cc_d;
  logic                     valid_q, valid_d;
  logic                     regwen_q, regwen_d;
  logic                     ccwen_q, ccwen_d;
  logic                     fault_q, fault_d;

`ifdef MEM_MMIO_EN
  logic [9:0]  ledr_q, ledr_d;
  logic [15:0] hex_q, hex_d;
  logic [`REG_WIDTH-1:0] mmio_word;
`endif

  assign is_load  = (I_Opcode == `OP_LDB) || (I_Opcode == `OP_LDW);
  assign is_store = (I_Opcode == `OP_STB) || (I_Opcode == `OP_STW);
  assign is_byte  = (I_Opcode == `OP_LDB) || (I_Opcode == `OP_STB);
  assign mem_op   = I_EX_Valid & I_LOCK & (is_load | is_store);
  assign ld       = mem_op & is_load;
  assign st       = mem_op & is_store;

  assign word_idx = I_MARValue[`REG_WIDTH-1:1];
  assign ram_idx  = word_idx[AW-1:0];
  assign in_range = 32'(word_idx) < DMEM_DEPTH;

`ifdef MEM_MMIO_EN
  assign mmio_hit  = (I_MARValue == 16'hFFF0) || (I_MARValue == 16'hFFF2);
  assign mmio_word = I_MARValue[1] ? hex_q : {6'b0, ledr_q};
`else
  assign mmio_hit  = 1'b0;
`endif

  // Zero-latency builds and MMIO registers finish in the IDLE cycle itself.
  assign fast  = (MEM_LATENCY == 0) || mmio_hit;
  assign stall = mem_op & (((state_q == S_IDLE) & ~fast) |
                           ((state_q == S_BUSY) & (cnt_q != 3'd0)));
  assign complete = mem_op & ~stall;

  assign O_MemStall_Signal = stall;
  assign O_RegWEn_Signal   = I_EX_Valid & (is_load | I_RegWEn);
  assign O_CCWEn_Signal    = I_EX_Valid & (is_load | I_CCWEn);

  assign rd_word = in_range ? mem[ram_idx] : '0;

  always_comb begin
`ifdef MEM_MMIO_EN
    raw_word = mmio_hit ? mmio_word : rd_word;
`else
    raw_word = rd_word;
`endif
    ld_lane = I_MARValue[0] ? raw_word[15:8] : raw_word[7:0];
    ld_data = is_byte ? `REG_WIDTH'(ld_lane) : raw_word;
    if (ld_data[`REG_WIDTH-1])   ld_cc = 3'b100;
    else if (ld_data == '0)      ld_cc = 3'b010;
    else                         ld_cc = 3'b001;
    // Byte stores merge into the current word so only one lane changes.
    wr_word = I_MDRValue;
    if (is_byte) begin
      wr_word = rd_word;
      if (I_MARValue[0]) wr_word[15:8] = I_MDRValue[7:0];
      else               wr_word[7:0]  = I_MDRValue[7:0];
    end
  end

  assign ram_we = ~I_RESET & complete & st & in_range & ~mmio_hit;

  always_ff @(negedge I_CLOCK) begin
    if (ram_we) mem[ram_idx] <= wr_word;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!I_LOCK) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        S_IDLE: if (mem_op && !fast) begin
          state_d = S_BUSY;
          cnt_d   = LAT_M1;
        end
        S_BUSY: begin
          if (!mem_op) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lock_d    = I_LOCK;
    opcode_d  = opcode_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    dst_idx_d = dst_idx_q;
    dst_val_d = dst_val_q;
    cc_d      = cc_q;
    valid_d   = 1'b0;
    regwen_d  = 1'b0;
    ccwen_d   = 1'b0;
    fault_d   = 1'b0;
`ifdef MEM_MMIO_EN
    ledr_d = ledr_q;
    hex_d  = hex_q;
    if (complete && (I_Opcode == `OP_STW) && mmio_hit) begin
      if (I_MARValue[1]) hex_d  = I_MDRValue;
      else               ledr_d = I_MDRValue[9:0];
    end
`endif
    // Locked-off and stalled cycles are bubbles; data fields hold.
    if (I_LOCK && !stall) begin
      opcode_d  = I_Opcode;
      pc_d      = I_PC;
      ir_d      = I_IR;
      dst_idx_d = I_DestRegIdx;
      dst_val_d = ld ? ld_data : I_DestValue;
      cc_d      = ld ? ld_cc : I_CCValue;
      valid_d   = I_EX_Valid;
      regwen_d  = ld | (I_EX_Valid & I_RegWEn & ~st);
      ccwen_d   = ld | (I_EX_Valid & I_CCWEn & ~st);
      fault_d   = mem_op & ~in_range & ~mmio_hit;
    end
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      lock_q    <= 1'b0;
      opcode_q  <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      dst_idx_q <= '0;
      dst_val_q <= '0;
      cc_q      <= '0;
      valid_q   <= 1'b0;
      regwen_q  <= 1'b0;
      ccwen_q   <= 1'b0;
      fault_q   <= 1'b0;
`ifdef MEM_MMIO_EN
      ledr_q    <= '0;
      hex_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      opcode_q  <= opcode_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      dst_idx_q <= dst_idx_d;
      dst_val_q <= dst_val_d;
      cc_q      <= cc_d;
      valid_q   <= valid_d;
      regwen_q  <= regwen_d;
      ccwen_q   <= ccwen_d;
      fault_q   <= fault_d;
`ifdef MEM_MMIO_EN
      ledr_q    <= ledr_d;
      hex_q     <= hex_d;
`endif
    end
  end

  assign O_LOCK       = lock_q;
  assign O_Opcode     = opcode_q;
  assign O_PC         = pc_q;
  assign O_IR         = ir_q;
  assign O_DestRegIdx = dst_idx_q;
  assign O_DestValue  = dst_val_q;
  assign O_CCValue    = cc_q;
  assign O_MEM_Valid  = valid_q;
  assign O_RegWEn     = regwen_q;
  assign O_CCWEn      = ccwen_q;
  assign O_AddrFault  = fault_q;
`ifdef MEM_MMIO_EN
  assign O_LEDR       = ledr_q;
  assign O_HEX        = hex_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (DMEM_DEPTH=1024, MEM_LATENCY=2).
`ifndef OP_LDB
`define OP_LDB 8'h20
`define OP_LDW 8'h21
`define OP_STB 8'h22
`define OP_STW 8'h23
`endif

module tb_mem_stage;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] LDB = `OP_LDB;
  localparam logic [7:0] LDW = `OP_LDW;
  localparam logic [7:0] STB = `OP_STB;
  localparam logic [7:0] STW = `OP_STW;

  logic clk;
  logic I_RESET, I_LOCK, I_EX_Valid, I_RegWEn, I_CCWEn;
  logic [7:0] I_Opcode;
  logic [15:0] I_PC, I_DestValue, I_MARValue, I_MDRValue;
  logic [31:0] I_IR;
  logic [3:0] I_DestRegIdx;
  logic [2:0] I_CCValue;
  logic O_LOCK, O_MEM_Valid, O_RegWEn, O_CCWEn, O_AddrFault;
  logic O_MemStall_Signal, O_RegWEn_Signal, O_CCWEn_Signal;
  logic [7:0] O_Opcode;
  logic [15:0] O_PC, O_DestValue;
  logic [31:0] O_IR;
  logic [3:0] O_DestRegIdx;
  logic [2:0] O_CCValue;
`ifdef MEM_MMIO_EN
  logic [9:0] O_LEDR;
  logic [15:0] O_HEX;
`endif

  int checks = 0;
  int failures = 0;

  mem_stage #(.DMEM_DEPTH(1024), .MEM_LATENCY(2)) dut (
    .I_CLOCK(clk), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_Opcode(I_Opcode),
    .I_PC(I_PC), .I_IR(I_IR), .I_DestRegIdx(I_DestRegIdx),
    .I_DestValue(I_DestValue), .I_CCValue(I_CCValue),
    .I_MARValue(I_MARValue), .I_MDRValue(I_MDRValue),
    .I_EX_Valid(I_EX_Valid), .I_RegWEn(I_RegWEn), .I_CCWEn(I_CCWEn),
    .O_LOCK(O_LOCK), .O_Opcode(O_Opcode), .O_PC(O_PC), .O_IR(O_IR),
    .O_DestRegIdx(O_DestRegIdx), .O_DestValue(O_DestValue),
    .O_CCValue(O_CCValue), .O_MEM_Valid(O_MEM_Valid), .O_RegWEn(O_RegWEn),
    .O_CCWEn(O_CCWEn), .O_AddrFault(O_AddrFault),
`ifdef MEM_MMIO_EN
    .O_LEDR(O_LEDR), .O_HEX(O_HEX),
`endif
    .O_MemStall_Signal(O_MemStall_Signal),
    .O_RegWEn_Signal(O_RegWEn_Signal), .O_CCWEn_Signal(O_CCWEn_Signal)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] op; logic v, l, rwe, cwe; logic [15:0] dv; logic [2:0] cc; logic [15:0] pc;
    logic e_v, e_rwe, e_cwe; logic [15:0] e_dv; logic [2:0] e_cc; logic [7:0] e_op;
    logic [15:0] e_pc; logic e_stall, e_rs, e_cs, e_lock;
  } vec_t;
  vec_t vecs[7];

  // Issue one load/store, follow it through its stall cycles, check its
  // output cycle, then drop I_EX_Valid and check the following bubble.
  task automatic do_mem(input string name, input logic [7:0] op, input logic [15:0] mar,
                        input logic [15:0] mdr, input int exp_stalls, input logic [15:0] exp_val,
                        input logic [2:0] exp_cc, input logic exp_we, input logic exp_fault);
    int stalls = 0;
    I_Opcode = op; I_MARValue = mar; I_MDRValue = mdr; I_EX_Valid = 1'b1; I_LOCK = 1'b1;
    I_RegWEn = 1'b0; I_CCWEn = 1'b0; I_DestValue = 16'h7777; I_CCValue = 3'b010;
    I_DestRegIdx = 4'h5; I_PC = 16'h0200; I_IR = 32'hC0DE0200;
    #1;
    while (O_MemStall_Signal === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk); #1;
      chk({name, "_bubble"}, {31'b0, O_MEM_Valid}, 32'd0);
    end
    chk({name, "_stalls"}, stalls, exp_stalls);
    @(negedge clk); #1;
    chk({name, "_valid"}, {31'b0, O_MEM_Valid}, 32'd1);
    chk({name, "_value"}, {16'b0, O_DestValue}, {16'b0, exp_val});
    chk({name, "_cc"}, {29'b0, O_CCValue}, {29'b0, exp_cc});
    chk({name, "_regwen"}, {31'b0, O_RegWEn}, {31'b0, exp_we});
    chk({name, "_ccwen"}, {31'b0, O_CCWEn}, {31'b0, exp_we});
    chk({name, "_fault"}, {31'b0, O_AddrFault}, {31'b0, exp_fault});
    chk({name, "_dst"}, {28'b0, O_DestRegIdx}, 32'h5);
    I_EX_Valid = 1'b0;
    @(negedge clk); #1;
    chk({name, "_after_valid"}, {31'b0, O_MEM_Valid}, 32'd0);
    chk({name, "_after_fault"}, {31'b0, O_AddrFault}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{OP_ADD,1,1,1,1,16'h1111,3'b001,16'h0100, 1,1,1,16'h1111,3'b001,OP_ADD,16'h0100, 0,1,1,1};
    vecs[1] = '{OP_ADD,1,1,1,0,16'h2222,3'b010,16'h0102, 1,1,0,16'h2222,3'b010,OP_ADD,16'h0102, 0,1,0,1};
    vecs[2] = '{OP_ADD,1,1,0,1,16'h8001,3'b100,16'h0104, 1,0,1,16'h8001,3'b100,OP_ADD,16'h0104, 0,0,1,1};
    vecs[3] = '{OP_ADD,0,1,1,1,16'h3333,3'b001,16'h0106, 0,0,0,16'h3333,3'b001,OP_ADD,16'h0106, 0,0,0,1};
    vecs[4] = '{LDW,   1,0,0,0,16'h4444,3'b010,16'h0108, 0,0,0,16'h3333,3'b001,OP_ADD,16'h0106, 0,1,1,0};
    vecs[5] = '{LDB,   0,1,1,1,16'h5555,3'b100,16'h010A, 0,0,0,16'h5555,3'b100,LDB,   16'h010A, 0,0,0,1};
    vecs[6] = '{STW,   1,0,1,0,16'h6666,3'b010,16'h010C, 0,0,0,16'h5555,3'b100,LDB,   16'h010A, 0,1,0,0};

    // Reset with ADD ops queued upstream.
    I_RESET = 1'b1; I_LOCK = 1'b1; I_EX_Valid = 1'b1; I_Opcode = OP_ADD;
    I_RegWEn = 1'b1; I_CCWEn = 1'b1; I_DestValue = 16'h1111; I_CCValue = 3'b001;
    I_PC = 16'h0100; I_IR = 32'hA5000100; I_DestRegIdx = 4'h1;
    I_MARValue = 16'h0; I_MDRValue = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {31'b0, O_MEM_Valid}, 32'd0);
    chk("rst_value", {16'b0, O_DestValue}, 32'd0);
    chk("rst_opcode", {24'b0, O_Opcode}, 32'd0);
    chk("rst_regwen", {31'b0, O_RegWEn}, 32'd0);
    chk("rst_lock", {31'b0, O_LOCK}, 32'd0);
    chk("rst_pc", {16'b0, O_PC}, 32'd0);
    I_RESET = 1'b0;

    for (int i = 0; i < 7; i++) begin
      I_Opcode = vecs[i].op; I_EX_Valid = vecs[i].v; I_LOCK = vecs[i].l;
      I_RegWEn = vecs[i].rwe; I_CCWEn = vecs[i].cwe; I_DestValue = vecs[i].dv;
      I_CCValue = vecs[i].cc; I_PC = vecs[i].pc; I_IR = {16'hA500, vecs[i].pc};
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, O_MemStall_Signal}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d_rwe_sig", i), {31'b0, O_RegWEn_Signal}, {31'b0, vecs[i].e_rs});
      chk($sformatf("v%0d_cwe_sig", i), {31'b0, O_CCWEn_Signal}, {31'b0, vecs[i].e_cs});
      @(negedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'b0, O_MEM_Valid}, {31'b0, vecs[i].e_v});
      chk($sformatf("v%0d_regwen", i), {31'b0, O_RegWEn}, {31'b0, vecs[i].e_rwe});
      chk($sformatf("v%0d_ccwen", i), {31'b0, O_CCWEn}, {31'b0, vecs[i].e_cwe});
      chk($sformatf("v%0d_value", i), {16'b0, O_DestValue}, {16'b0, vecs[i].e_dv});
      chk($sformatf("v%0d_cc", i), {29'b0, O_CCValue}, {29'b0, vecs[i].e_cc});
      chk($sformatf("v%0d_opcode", i), {24'b0, O_Opcode}, {24'b0, vecs[i].e_op});
      chk($sformatf("v%0d_pc", i), {16'b0, O_PC}, {16'b0, vecs[i].e_pc});
      chk($sformatf("v%0d_ir", i), O_IR, {16'hA500, vecs[i].e_pc});
      chk($sformatf("v%0d_lock", i), {31'b0, O_LOCK}, {31'b0, vecs[i].e_lock});
    end
    I_LOCK = 1'b1; I_EX_Valid = 1'b0;
    @(negedge clk); #1;

    // Word store/load, CC negative.
    do_mem("stw10", STW, 16'h0010, 16'hBEEF, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    do_mem("ldw10", LDW, 16'h0010, 16'h0000, 2, 16'hBEEF, 3'b100, 1'b1, 1'b0);
    // Byte lanes.
    do_mem("stw10b", STW, 16'h0010, 16'h1234, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    do_mem("stb11", STB, 16'h0011, 16'h00AA, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    do_mem("ldw10c", LDW, 16'h0010, 16'h0000, 2, 16'hAA34, 3'b100, 1'b1, 1'b0);
    do_mem("ldb11", LDB, 16'h0011, 16'h0000, 2, 16'h00AA, 3'b001, 1'b1, 1'b0);
    do_mem("ldb10", LDB, 16'h0010, 16'h0000, 2, 16'h0034, 3'b001, 1'b1, 1'b0);
    do_mem("stb10", STB, 16'h0010, 16'hFF5A, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    do_mem("ldw10d", LDW, 16'h0011, 16'h0000, 2, 16'hAA5A, 3'b100, 1'b1, 1'b0);
    // Zero CC.
    do_mem("stw12", STW, 16'h0012, 16'h0000, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    do_mem("ldw12", LDW, 16'h0012, 16'h0000, 2, 16'h0000, 3'b010, 1'b1, 1'b0);
    // Range boundary and out-of-range accesses.
    do_mem("stw0", STW, 16'h0000, 16'h0101, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    do_mem("stw7fe", STW, 16'h07FE, 16'h4321, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    do_mem("ldw7ff", LDW, 16'h07FF, 16'h0000, 2, 16'h4321, 3'b001, 1'b1, 1'b0);
    do_mem("ldw800", LDW, 16'h0800, 16'h0000, 2, 16'h0000, 3'b010, 1'b1, 1'b1);
    do_mem("stw800", STW, 16'h0800, 16'hDEAD, 2, 16'h7777, 3'b010, 1'b0, 1'b1);
    do_mem("ldw0", LDW, 16'h0000, 16'h0000, 2, 16'h0101, 3'b001, 1'b1, 1'b0);

    // Reset during BUSY aborts the pending store.
    do_mem("stw20", STW, 16'h0020, 16'h1357, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    I_Opcode = STW; I_MARValue = 16'h0020; I_MDRValue = 16'h5555; I_EX_Valid = 1'b1;
    @(negedge clk); #1;
    I_RESET = 1'b1;
    @(negedge clk); #1;
    chk("rstbusy_valid", {31'b0, O_MEM_Valid}, 32'd0);
    chk("rstbusy_value", {16'b0, O_DestValue}, 32'd0);
    chk("rstbusy_opcode", {24'b0, O_Opcode}, 32'd0);
    chk("rstbusy_idle_stall", {31'b0, O_MemStall_Signal}, 32'd1);
    I_RESET = 1'b0; I_EX_Valid = 1'b0;
    @(negedge clk); #1;
    do_mem("ldw20", LDW, 16'h0020, 16'h0000, 2, 16'h1357, 3'b001, 1'b1, 1'b0);

    // Reset on the completing edge wins.
    do_mem("stw22", STW, 16'h0022, 16'h2468, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    I_Opcode = STW; I_MARValue = 16'h0022; I_MDRValue = 16'h9999; I_EX_Valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    I_RESET = 1'b1;
    @(negedge clk); #1;
    chk("rstdone_valid", {31'b0, O_MEM_Valid}, 32'd0);
    I_RESET = 1'b0; I_EX_Valid = 1'b0;
    @(negedge clk); #1;
    do_mem("ldw22", LDW, 16'h0022, 16'h0000, 2, 16'h2468, 3'b001, 1'b1, 1'b0);

    // Dropping I_LOCK mid-access forces IDLE with no write.
    do_mem("stw24", STW, 16'h0024, 16'h0F0F, 2, 16'h7777, 3'b010, 1'b0, 1'b0);
    I_Opcode = STW; I_MARValue = 16'h0024; I_MDRValue = 16'hAAAA; I_EX_Valid = 1'b1;
    @(negedge clk); #1;
    I_LOCK = 1'b0;
    @(negedge clk); #1;
    chk("lock0_valid", {31'b0, O_MEM_Valid}, 32'd0);
    chk("lock0_olock", {31'b0, O_LOCK}, 32'd0);
    I_LOCK = 1'b1; I_EX_Valid = 1'b0;
    @(negedge clk); #1;
    do_mem("ldw24", LDW, 16'h0024, 16'h0000, 2, 16'h0F0F, 3'b001, 1'b1, 1'b0);

`ifdef MEM_MMIO_EN
    do_mem("mmio_stw", STW, 16'hFFF0, 16'h03FF, 0, 16'h7777, 3'b010, 1'b0, 1'b0);
    chk("mmio_ledr", {22'b0, O_LEDR}, 32'h3FF);
    do_mem("mmio_ldw", LDW, 16'hFFF0, 16'h0000, 0, 16'h03FF, 3'b001, 1'b1, 1'b0);
    do_mem("mmio_hex", STW, 16'hFFF2, 16'h8421, 0, 16'h7777, 3'b010, 1'b0, 1'b0);
    chk("mmio_hexval", {16'b0, O_HEX}, 32'h8421);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
